mux_tree_pipe: RTL and testbench
================================

Name: mux_tree_pipe

Overview:
- Parametrised N:1, WIDTH-bit multiplexer built as a binary tree of 2:1 levels, with a registered output and optional per-level pipeline registers.
- Carries a valid bit and the select value alongside the data.
- Generalises the single-bit 2:1 mux into the register-file read-port selector: it picks one of N register words per request and sustains one request per cycle.

Parameters:
- WIDTH, 64, data bits per input slot and output.
- N, 32, number of input slots; power of two, N >= 2.
- PIPE, 1, 1 = register after every tree level; 0 = full combinational tree followed by a single output register.
- Derived: L = log2(N) tree levels; SW = log2(N) select bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 freezes every register (stall).
- in_valid  in  1  request present on sel/din this cycle.
- sel  in  SW  slot index to select.
- din  in  N*WIDTH  flattened inputs; slot i = din[i*WIDTH +: WIDTH].
- dout  out  WIDTH  selected word, registered.
- out_valid  out  1  dout/out_sel hold a completed request.
- out_sel  out  SW  sel value of the request currently on dout.

Behaviour:
- Reset: synchronous, active-high. On a rising edge with reset=1, every stage register clears: data=0, valid=0, sel copy=0. Therefore dout=0, out_valid=0, out_sel=0. Reset overrides en.
- Reset mid-operation discards all in-flight requests. No output is produced for them.

Tree structure:
- Level k (k = 0..L-1) halves the candidate set using sel bit k, LSB first.
- Element j of level k = (selbit_k ? cand[2j+1] : cand[2j]).
- Level 0 candidates are the N din slots. Level L-1 yields one word.

Registers and latency:
- PIPE=1: a register follows each level. Level-0 register holds N/2 words plus valid plus full sel. Latency from in_valid sample to out_valid = L cycles.
- PIPE=0: one register after the full tree. Latency = 1 cycle.
- Throughput: one request per cycle when en=1, with no bubbles required.

Data capture:
- Only the reduced words propagate. Changes to din after the level-0 (or only) register captures cannot affect that request.

Valid gating:
- A stage loading valid=0 also loads data=0 and sel=0.
- Hence out_valid=0 implies dout=0 and out_sel=0.

Stall:
- When en=0 and reset=0, all registers, including valid bits, hold.
- in_valid/sel/din presented while en=0 are ignored, not queued.
- No back-pressure output exists. The upstream must hold or re-present the request.

Simultaneous events:
- reset=1 with en=0 → reset wins.
- in_valid=1 with reset=1 → request dropped.

Boundary values:
- sel=0 selects slot 0; sel=N-1 selects slot N-1. There is no out-of-range case.
- N=2 gives L=1, so PIPE=1 and PIPE=0 produce identical timing.

Test Plan:
1. WIDTH=8, N=4, PIPE=1; din slots {0:0xA0, 1:0xB1, 2:0xC2, 3:0xD3}; reset 2 cycles; in_valid=1, sel=2 for one cycle → exactly 2 cycles later dout=0xC2, out_valid=1, out_sel=2; next cycle out_valid=0, dout=0x00.
2. Same config; sel=0,1,2,3 on consecutive cycles with in_valid=1 → dout=0xA0,0xB1,0xC2,0xD3 on four consecutive cycles starting at cycle 2, with out_valid continuously 1.
3. Same stream as scenario 2; drive en=0 for 3 cycles after the second request enters → outputs freeze with the current dout/out_valid values; after en=1 the sequence resumes with no loss or duplication.
4. Request sel=3 enters; on the next cycle set din slot 3=0xFF and assert reset=1 → dout=0, out_valid=0 on the following edge; no 0xD3 or 0xFF ever appears.
5. PIPE=0, WIDTH=8, N=4; sel=1, in_valid=1 → dout=0xB1, out_valid=1, out_sel=1 one cycle later.
6. Capture isolation, PIPE=1, N=4: request sel=1 with slot 1=0xB1, then change slot 1 to 0x55 the following cycle → output 0xB1.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N:1 WIDTH-bit selector built as a binary tree of 2:1 levels.
// Level k uses select bit k (LSB first) to halve its candidate set. With
// PIPE=1 every level is registered; with PIPE=0 the whole tree is
// combinational and only the final level is registered. The select value and
// a valid bit travel with the data so the output carries its own request tag.
//
// All level outputs live in one flat vector laid out level by level:
// level k occupies words [N - (N>>k), N - (N>>(k+1))), giving N-1 words total
// with the final selected word at index N-2.
module mux_tree_pipe #(
  parameter int WIDTH = 64,
  parameter int N     = 32,
  parameter int PIPE  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic [N*WIDTH-1:0]     din,
  output logic [WIDTH-1:0]       dout,
  output logic                   out_valid,
  output logic [$clog2(N)-1:0]   out_sel
);

  localparam int L  = $clog2(N);
  localparam int SW = $clog2(N);

  // Outputs of every level (registered or pass-through, depending on PIPE).
  wire [(N-1)*WIDTH-1:0] stage_data;
  wire [L*SW-1:0]        stage_sel;
  wire [L-1:0]           stage_valid;

  genvar gi, gj;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lvl
      localparam int M       = N >> (gi + 1);   // words produced by this level
      localparam int OUT_OFF = N - (N >> gi);   // word offset of this level

      wire [2*M*WIDTH-1:0] cand;
      wire [SW-1:0]        sel_in;
      wire                 valid_in;
      wire [M*WIDTH-1:0]   mux_d;

      // Candidates come from the input slots for level 0, otherwise from the
      // previous level's output.
      if (gi == 0) begin : g_src_in
        assign cand     = din;
        assign sel_in   = sel;
        assign valid_in = in_valid;
      end else begin : g_src_prev
        localparam int IN_OFF = N - (N >> (gi - 1));
        assign cand     = stage_data[IN_OFF*WIDTH +: 2*M*WIDTH];
        assign sel_in   = stage_sel[(gi-1)*SW +: SW];
        assign valid_in = stage_valid[gi-1];
      end

      // Pairwise 2:1 reduction steered by select bit gi.
      for (gj = 0; gj < M; gj++) begin : g_mux
        assign mux_d[gj*WIDTH +: WIDTH] = sel_in[gi] ? cand[(2*gj+1)*WIDTH +: WIDTH]
                                                     : cand[(2*gj)*WIDTH +: WIDTH];
      end

      if (PIPE != 0 || gi == L - 1) begin : g_reg
        logic [M*WIDTH-1:0] data_q;
        logic [M*WIDTH-1:0] data_d;
        logic [SW-1:0]      sel_q;
        logic [SW-1:0]      sel_d;
        logic               valid_q;

        // Empty slots load zero data and select so idle outputs are clean.
        assign data_d = valid_in ? mux_d  : '0;
        assign sel_d  = valid_in ? sel_in : '0;

        // Level register: reset clears, en=0 holds everything including valid.
        always_ff @(posedge clk) begin
          if (reset) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
          end else if (en) begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_in;
          end
        end

        assign stage_data[OUT_OFF*WIDTH +: M*WIDTH] = data_q;
        assign stage_sel[gi*SW +: SW]               = sel_q;
        assign stage_valid[gi]                      = valid_q;
      end else begin : g_comb
        assign stage_data[OUT_OFF*WIDTH +: M*WIDTH] = mux_d;
        assign stage_sel[gi*SW +: SW]               = sel_in;
        assign stage_valid[gi]                      = valid_in;
      end
    end
  endgenerate

  assign dout      = stage_data[(N-2)*WIDTH +: WIDTH];
  assign out_sel   = stage_sel[(L-1)*SW +: SW];
  assign out_valid = stage_valid[L-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three instances share control inputs.
//   dut 0: WIDTH=8,  N=4, PIPE=1 (latency 2)
//   dut 1: WIDTH=8,  N=4, PIPE=0 (latency 1)
//   dut 2: WIDTH=16, N=8, PIPE=1 (latency 3)
// Accepted requests are pushed into per-instance queues with the index of the
// enabled edge that accepted them; the monitor pops a request once it has aged
// by latency-1 further enabled edges and compares it with the DUT output.
module tb_mux_tree_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         in_valid;
  logic [1:0]   sel_a;
  logic [31:0]  din_a;
  logic [2:0]   sel_c;
  logic [127:0] din_c;

  logic [7:0]   dout_0, dout_1;
  logic [15:0]  dout_2;
  logic         out_valid_0, out_valid_1, out_valid_2;
  logic [1:0]   out_sel_0, out_sel_1;
  logic [2:0]   out_sel_2;

  mux_tree_pipe #(.WIDTH(8), .N(4), .PIPE(1)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .sel(sel_a),
    .din(din_a), .dout(dout_0), .out_valid(out_valid_0), .out_sel(out_sel_0));

  mux_tree_pipe #(.WIDTH(8), .N(4), .PIPE(0)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .sel(sel_a),
    .din(din_a), .dout(dout_1), .out_valid(out_valid_1), .out_sel(out_sel_1));

  mux_tree_pipe #(.WIDTH(16), .N(8), .PIPE(1)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .sel(sel_c),
    .din(din_c), .dout(dout_2), .out_valid(out_valid_2), .out_sel(out_sel_2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [2:0]  s;
    logic [15:0] d;
    int unsigned tag;
  } tok_t;

  tok_t        exp_q [3][$];
  tok_t        exp_cur [3];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          started = 1'b0;
  bit          last_rst = 1'b0;
  bit          last_en = 1'b0;
  int unsigned edge_cnt = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
  endfunction

  // Reference model: record what each rising edge does to the request stream.
  always @(posedge clk) begin : recorder
    tok_t t;
    last_rst = reset;
    last_en  = en;
    if (reset) begin
      started = 1'b1;
      for (int d = 0; d < 3; d++) exp_q[d].delete();
    end else if (en) begin
      edge_cnt++;
      if (in_valid) begin
        t     = '0;
        t.v   = 1'b1;
        t.tag = edge_cnt;
        t.s   = {1'b0, sel_a};
        t.d   = {8'h00, din_a[sel_a*8 +: 8]};
        exp_q[0].push_back(t);
        exp_q[1].push_back(t);
        t.s   = sel_c;
        t.d   = din_c[sel_c*16 +: 16];
        exp_q[2].push_back(t);
      end
    end
  end

  // Monitor: away from the active edge, derive the expected output of each
  // instance from the queue and compare with what the DUT presents.
  always @(negedge clk) begin : monitor
    tok_t act [3];
    if (started) begin
      act[0] = '0; act[0].v = out_valid_0; act[0].s = {1'b0, out_sel_0}; act[0].d = {8'h00, dout_0};
      act[1] = '0; act[1].v = out_valid_1; act[1].s = {1'b0, out_sel_1}; act[1].d = {8'h00, dout_1};
      act[2] = '0; act[2].v = out_valid_2; act[2].s = out_sel_2;         act[2].d = dout_2;
      for (int d = 0; d < 3; d++) begin
        if (last_rst) begin
          exp_cur[d] = '0;
        end else if (last_en) begin
          exp_cur[d] = '0;
          if (exp_q[d].size() > 0 && (edge_cnt - exp_q[d][0].tag) == lat(d) - 1)
            exp_cur[d] = exp_q[d].pop_front();
        end
        n_cmp++;
        if ({act[d].v, act[d].s, act[d].d} !== {exp_cur[d].v, exp_cur[d].s, exp_cur[d].d}) begin
          n_err++;
          $display("FAIL out_dut%0d t=%0t: got valid=%0b sel=%0d dout=%h, expected valid=%0b sel=%0d dout=%h",
                   d, $time, act[d].v, act[d].s, act[d].d, exp_cur[d].v, exp_cur[d].s, exp_cur[d].d);
        end
      end
    end
  end

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [1:0] s, input logic [2:0] sc);
    reset    = r;
    en       = e;
    in_valid = v;
    sel_a    = s;
    sel_c    = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 3'd0);
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    in_valid = 1'b0;
    sel_a    = 2'd0;
    sel_c    = 3'd0;
    din_a    = 32'hD3C2_B1A0;
    din_c    = {$urandom, $urandom, $urandom, $urandom};

    // Two reset cycles.
    step(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 3'd0);

    // Single request, then drain.
    step(1'b0, 1'b1, 1'b1, 2'd2, 3'd5);
    idle(4);

    // Back-to-back requests over every slot.
    for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 1'b1, 2'(s), 3'(s + 4));
    idle(4);

    // Stall for three cycles after the second request; inputs ignored meanwhile.
    step(1'b0, 1'b1, 1'b1, 2'd0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 2'd1, 3'd7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'd3, 3'd3);
    step(1'b0, 1'b1, 1'b1, 2'd2, 3'd2);
    step(1'b0, 1'b1, 1'b1, 2'd3, 3'd4);
    idle(4);

    // Reset while a request is in flight; slot 3 changes in the same cycle.
    step(1'b0, 1'b1, 1'b1, 2'd3, 3'd6);
    din_a[31:24] = 8'hFF;
    step(1'b1, 1'b1, 1'b1, 2'd3, 3'd6);
    idle(4);
    din_a = 32'hD3C2_B1A0;

    // Capture isolation: slot changes the cycle after the request enters.
    step(1'b0, 1'b1, 1'b1, 2'd1, 3'd1);
    din_a[15:8] = 8'h55;
    idle(4);
    din_a = 32'hD3C2_B1A0;

    // Reset together with en=0 must still clear in-flight work.
    step(1'b0, 1'b1, 1'b1, 2'd2, 3'd2);
    step(1'b1, 1'b0, 1'b1, 2'd1, 3'd1);
    idle(3);

    // Randomised traffic with stalls and occasional resets.
    for (int i = 0; i < 600; i++) begin
      din_a = $urandom;
      din_c = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    end
    idle(6);

    // Every accepted request must have emerged.
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (exp_q[d].size() != 0) begin
        n_err++;
        $display("FAIL drain_dut%0d: %0d requests never emerged, expected 0", d, exp_q[d].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
